// File: rtl/spi_frame_counter.sv
// Frame counter for SPI transfers: counts T+1 enabled beats per frame,
// up or down, one-shot or auto-restart, and tallies completed frames.
module spi_frame_counter #(
  parameter int CNT_W = 4,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             clear,
  input  logic             mode_oneshot,
  input  logic             dir_down,
  input  logic [CNT_W-1:0] term_cnt,
  output logic [CNT_W-1:0] count,
  output logic             term_flag,
  output logic             done,
  output logic             busy,
  output logic [FRM_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE = FRM_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             dir_q, dir_d;
  logic             os_q, os_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             term_q, term_d;
  logic [CNT_W-1:0] beg_in, beg_q, fin_q, fin_d;

  // Next-state and registered-output logic: clear > start > enable
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    t_d     = t_q;
    dir_d   = dir_q;
    os_d    = os_q;
    frm_d   = frm_q;
    done_d  = 1'b0;
    beg_in  = dir_down ? term_cnt : '0;
    beg_q   = dir_q ? t_q : '0;
    fin_q   = dir_q ? '0 : t_q;
    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      frm_d   = '0;
    end else if (start) begin
      state_d = S_RUN;
      t_d     = term_cnt;
      dir_d   = dir_down;
      os_d    = mode_oneshot;
      count_d = beg_in;
    end else if (state_q == S_RUN && enable) begin
      if (count_q == fin_q) begin
        done_d = 1'b1;
        frm_d  = frm_q + FRM_ONE;
        if (os_q) begin
          state_d = S_DONE;
        end else begin
          count_d = beg_q;
        end
      end else if (dir_q) begin
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
    fin_d  = dir_d ? '0 : t_d;
    busy_d = (state_d == S_RUN);
    term_d = (state_d != S_IDLE) && (count_d == fin_d);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      t_q     <= '0;
      dir_q   <= 1'b0;
      os_q    <= 1'b0;
      frm_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      term_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      t_q     <= t_d;
      dir_q   <= dir_d;
      os_q    <= os_d;
      frm_q   <= frm_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      term_q  <= term_d;
    end
  end

  assign count     = count_q;
  assign term_flag = term_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign frame_cnt = frm_q;

endmodule

// File: tb/tb_spi_frame_counter.sv
// Randomized and directed bench for spi_frame_counter against a
// frame-position reference model.
module tb_spi_frame_counter;

  localparam int CW = 4;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          mode_oneshot = 1'b0;
  logic          dir_down = 1'b0;
  logic [CW-1:0] term_cnt = '0;
  logic [CW-1:0] count;
  logic          term_flag;
  logic          done;
  logic          busy;
  logic [FW-1:0] frame_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: position within the current frame
  bit m_run, m_stop, m_dn, m_os, m_done;
  int m_t, m_pos, m_frames;

  spi_frame_counter #(.CNT_W(CW), .FRM_W(FW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .clear        (clear),
    .mode_oneshot (mode_oneshot),
    .dir_down     (dir_down),
    .term_cnt     (term_cnt),
    .count        (count),
    .term_flag    (term_flag),
    .done         (done),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_stop = 0; m_pos = 0;
    m_frames = 0; m_done = 0;
    m_t = 0; m_dn = 0; m_os = 0;
  endtask

  task automatic m_step();
    m_done = 0;
    if (clear) begin
      m_run = 0; m_stop = 0; m_pos = 0; m_frames = 0;
    end else if (start) begin
      m_run = 1; m_stop = 0; m_pos = 0;
      m_t = int'(term_cnt); m_dn = dir_down; m_os = mode_oneshot;
    end else if (m_run && enable) begin
      if (m_pos == m_t) begin
        m_done = 1;
        m_frames++;
        if (m_os) begin
          m_run = 0; m_stop = 1;
        end else begin
          m_pos = 0;
        end
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int e_cnt;
    bit act;
    act = m_run || m_stop;
    e_cnt = !act ? 0 : (m_dn ? m_t - m_pos : m_pos);
    chk({tag, ".count"}, int'(count), e_cnt);
    chk({tag, ".busy"}, int'(busy), int'(m_run));
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".term"}, int'(term_flag), int'(act && m_pos == m_t));
    chk({tag, ".frm"}, int'(frame_cnt), m_frames % (1 << FW));
  endtask

  task automatic cyc(input string tag, input bit e, input bit s, input bit c);
    enable = e; start = s; clear = c;
    @(posedge clk);
    m_step();
    #1;
    check_all(tag);
    enable = 0; start = 0; clear = 0;
  endtask

  task automatic setup(input int t, input bit dn, input bit os);
    term_cnt = CW'(t); dir_down = dn; mode_oneshot = os;
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk({tag, ".count"}, int'(count), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".frm"}, int'(frame_cnt), 0);
    chk({tag, ".done"}, int'(done), 0);
    chk({tag, ".term"}, int'(term_flag), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    m_reset();
    #1;
    check_all("por");
    @(negedge clk);
    reset = 1'b1;
    cyc("idle_en", 1, 0, 0);

    // up one-shot, T=9
    setup(9, 0, 1);
    cyc("up_start", 0, 1, 0);
    setup(2, 1, 0);
    for (int i = 0; i < 13; i++) cyc("up_os", 1, 0, 0);

    // down auto-restart, T=3
    setup(3, 1, 0);
    cyc("dn_start", 0, 1, 0);
    for (int i = 0; i < 12; i++) cyc("dn_auto", 1, 0, 0);

    // enable gaps, T=5
    setup(5, 0, 1);
    cyc("gap_start", 0, 1, 0);
    for (int i = 0; i < 14; i++) cyc("gap", i[0] == 1'b0, 0, 0);

    // start colliding with the completing enable
    setup(2, 0, 0);
    cyc("col_start", 0, 1, 0);
    cyc("col_a", 1, 0, 0);
    cyc("col_b", 1, 0, 0);
    setup(4, 1, 0);
    cyc("col_restart", 1, 1, 0);
    cyc("col_c", 1, 0, 0);
    cyc("clr_start", 1, 1, 1);
    cyc("clr_idle", 1, 0, 0);

    // T=0 auto-restart, frame counter wrap
    setup(0, 0, 0);
    cyc("t0_start", 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc("t0", 1, 0, 0);

    // async reset mid-frame
    setup(7, 0, 0);
    cyc("rst_start", 0, 1, 0);
    cyc("rst_a", 1, 0, 0);
    cyc("rst_b", 1, 0, 0);
    async_reset("rst_async");
    cyc("rst_after", 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      setup(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cyc("rnd", $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 39) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_counter.md
SPI_FRAME_COUNTER -- requirements
Module: spi_frame_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the count and terminal-value width.
REQ-002 The block SHALL have parameter FRM_W, default 8, giving the completed-frame counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: count-advance qualifier, one step per cycle while high.
REQ-006 The block SHALL have port start, input, 1 bit: begin or restart a frame.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous clear.
REQ-008 The block SHALL have port mode_oneshot, input, 1 bit: 1 = stop after one frame; 0 = auto-restart. Sampled at start.
REQ-009 The block SHALL have port dir_down, input, 1 bit: 0 = count up, 1 = count down. Sampled at start.
REQ-010 The block SHALL have port term_cnt, input, CNT_W bits: terminal value T. Sampled at start.
REQ-011 The block SHALL have port count, output, CNT_W bits: current count.
REQ-012 The block SHALL have port term_flag, output, 1 bit: level, high while count equals the end value and state is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse per completed frame.
REQ-014 The block SHALL have port busy, output, 1 bit: high in state RUN.
REQ-015 The block SHALL have port frame_cnt, output, FRM_W bits: number of completed frames, modulo 2^FRM_W.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-017 On start, the block SHALL latch T, dir_down and mode_oneshot into internal registers; later changes on these inputs SHALL have no effect until the next start.
REQ-018 The start value SHALL be 0 for up mode and T for down mode; the end value SHALL be T for up mode and 0 for down mode.
REQ-019 On start in any state, the next cycle SHALL show state RUN, count = start value, busy = 1 and done = 0.
REQ-020 In RUN, enable = 1 with count != end SHALL step count by +1 (up) or -1 (down) in the next cycle; enable = 0 SHALL hold count.
REQ-021 In RUN, enable = 1 with count == end SHALL complete the frame: the next cycle SHALL show done = 1 for exactly one cycle and frame_cnt incremented by 1.
REQ-022 On frame completion with oneshot = 0, count SHALL reload the start value and the state SHALL remain RUN, with no idle cycle.
REQ-023 On frame completion with oneshot = 1, the state SHALL go to DONE, count SHALL hold the end value, busy SHALL be 0, and term_flag SHALL stay 1.
REQ-024 A frame SHALL be exactly T+1 enabled cycles; T = 0 SHALL give a one-enable frame with term_flag high from the start.
REQ-025 In IDLE and DONE, enable SHALL be ignored.
REQ-026 Priority SHALL be clear > start > enable.
REQ-027 start coincident with a frame-completing enable SHALL restart the frame with no done pulse and no frame_cnt increment.
REQ-028 start in RUN mid-frame SHALL restart the frame (re-sample T, dir_down and mode_oneshot) with no done pulse.
REQ-029 clear SHALL, in the next cycle, set state IDLE, count 0, frame_cnt 0, done 0, term_flag 0 and busy 0.
REQ-030 frame_cnt SHALL wrap from 2^FRM_W-1 to 0 without a flag.
REQ-031 Counting SHALL never leave the range 0..T; no CNT_W wrap SHALL occur within a frame.

Reset
REQ-032 While reset = 0, the block SHALL immediately, independent of clk, force state IDLE, count 0, term_flag 0, done 0, busy 0 and frame_cnt 0, and clear the latched T, direction and mode.
REQ-033 When reset is asserted mid-frame, the frame SHALL be abandoned with no done pulse.
REQ-034 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-035 The bench SHALL cover reset: assert reset = 0 mid-RUN -> count 0, busy 0, frame_cnt 0 without a clock edge.
REQ-036 The bench SHALL cover up one-shot: T = 9, up, oneshot, start, then enable held -> count 0..9; term_flag high at count 9; after the 10th enable, done pulses once, frame_cnt = 1, state DONE with count 9; further enables change nothing.
REQ-037 The bench SHALL cover down auto-restart: T = 3, down, oneshot = 0, enable held for 12 cycles -> count sequence 3,2,1,0 repeated 3 times, 3 done pulses, frame_cnt = 3, busy stays high.
REQ-038 The bench SHALL cover enable gaps: T = 5, up, enable toggled 1/0 -> count advances only on enabled cycles; done arrives after exactly 6 enables.
REQ-039 The bench SHALL cover collisions: start with the frame-completing enable -> count = start value, no done; clear with start -> IDLE, count 0.
REQ-040 The bench SHALL cover T = 0 and wrap: T = 0, FRM_W = 2, auto-restart, 5 enables -> 5 done pulses; frame_cnt 1,2,3,0,1.
